alu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the single-op datapath ALU. Supports the full 3-bit

---
 rtl/alu_pipe_pkg.sv | 25 ++
 rtl/alu_pipe_core.sv | 97 +++++++++
 rtl/alu_pipe.sv | 122 ++++++++++++
 tb/tb_alu_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// ----------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the pipelined ALU: the 3-bit operation codes and the
// bit positions of the {N,V,C,Z} status flags inside the 4-bit flags word.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_func_e;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// ----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: {func, a, b} -> {result, flags}.
// Ports:
//   func   in  3       operation code (alu_func_e)
//   a      in  DWIDTH  operand A
//   b      in  DWIDTH  operand B (shift amount = low clog2(DWIDTH) bits)
//   result out DWIDTH  result, wrapping modulo 2^DWIDTH
//   flags  out 4       {N,V,C,Z} describing result
// ----------------------------------------------------------------------------
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic [2:0]        func,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result,
    output logic [3:0]        flags
);

    localparam int SHW = $clog2(DWIDTH);

    logic [SHW-1:0]  shamt;
    logic [DWIDTH:0] sum;
    logic [DWIDTH:0] diff;
    logic [DWIDTH:0] sll_ext;
    logic [DWIDTH:0] srl_ext;
    logic [DWIDTH:0] sra_ext;
    logic            carry;
    logic            ovf;

    assign shamt = b[SHW-1:0];

    // Arithmetic is one bit wider so the top bit is the carry (ADD) or the
    // borrow (SUB).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Shifts use one guard bit on the side the data leaves from, so the
    // last bit shifted out lands in the guard and a zero amount leaves 0.
    assign sll_ext = {1'b0, a} << shamt;
    assign srl_ext = {a, 1'b0} >> shamt;
    assign sra_ext = $unsigned($signed({a, 1'b0}) >>> shamt);

    // Result and carry/overflow selection
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_func_e'(func))
            ALU_ADD: begin
                result = sum[DWIDTH-1:0];
                carry  = sum[DWIDTH];
                ovf    = (a[DWIDTH-1] == b[DWIDTH-1]) &&
                         (sum[DWIDTH-1] != a[DWIDTH-1]);
            end
            ALU_SUB: begin
                result = diff[DWIDTH-1:0];
                carry  = ~diff[DWIDTH];
                ovf    = (a[DWIDTH-1] != b[DWIDTH-1]) &&
                         (diff[DWIDTH-1] != a[DWIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: begin
                result = sll_ext[DWIDTH-1:0];
                carry  = sll_ext[DWIDTH];
            end
            ALU_SRL: begin
                result = srl_ext[DWIDTH:1];
                carry  = srl_ext[0];
            end
            ALU_SRA: begin
                result = sra_ext[DWIDTH:1];
                carry  = sra_ext[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
        endcase
    end

    // Flag word assembly
    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (result == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
        flags[FLG_N] = result[DWIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
// Pipelined ALU with valid/ready handshakes on both sides. Operands go through
// alu_core into stage 1, then ripple through stages 2..STAGES. Empty stages
// always accept, so bubbles collapse under backpressure.
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous active-high reset
//   in_valid   in   1       operands/func valid
//   in_ready   out  1       pipeline accepts operands this cycle
//   alu_func   in   3       operation code
//   alu_a      in   DWIDTH  operand A
//   alu_b      in   DWIDTH  operand B
//   out_valid  out  1       result/flags valid
//   out_ready  in   1       consumer takes result this cycle
//   alu_out    out  DWIDTH  result
//   flags      out  4       {N,V,C,Z}
//   ovf_sticky out  1       set by any delivered op with V=1
//   clr_sticky in   1       synchronous clear of ovf_sticky (set wins)
// ----------------------------------------------------------------------------
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_func,
    input  logic [DWIDTH-1:0] alu_a,
    input  logic [DWIDTH-1:0] alu_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              ovf_sticky,
    input  logic              clr_sticky
);

    logic [DWIDTH-1:0] core_res;
    logic [3:0]        core_flg;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [DWIDTH-1:0] stage_res [STAGES];
    logic [3:0]        stage_flg [STAGES];

    logic              out_xfer;

    alu_core #(
        .DWIDTH (DWIDTH)
    ) u_core (
        .func   (alu_func),
        .a      (alu_a),
        .b      (alu_b),
        .result (core_res),
        .flags  (core_flg)
    );

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              v_in;
        logic [DWIDTH-1:0] r_in;
        logic [3:0]        f_in;
        logic              v_q;
        logic [DWIDTH-1:0] r_q;
        logic [3:0]        f_q;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign r_in = core_res;
            assign f_in = core_flg;
        end else begin : g_body
            assign v_in = vld[k-1];
            assign r_in = stage_res[k-1];
            assign f_in = stage_flg[k-1];
        end

        // Stage k may load whenever some stage from k to the output is empty
        // or the consumer is taking the last stage. This is the unrolled form
        // of "empty or downstream advancing" and avoids a combinational chain
        // through the adv vector itself.
        assign adv[k] = out_ready || !(&vld[STAGES-1:k]);

        // Stage register: valid bit plus result/flags payload
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                r_q <= '0;
                f_q <= '0;
            end else if (adv[k]) begin
                v_q <= v_in;
                r_q <= r_in;
                f_q <= f_in;
            end
        end

        assign vld[k]       = v_q;
        assign stage_res[k] = r_q;
        assign stage_flg[k] = f_q;
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign alu_out   = stage_res[STAGES-1];
    assign flags     = stage_flg[STAGES-1];
    assign out_xfer  = out_valid && out_ready;

    // Overflow sticky: a delivered V=1 op takes priority over a clear
    // arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_xfer && flags[FLG_V]) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe. A STAGES=2 instance takes directed
// scenarios; STAGES=1,3,4 instances take randomized throttled traffic checked
// against a behavioural reference model and an in-order scoreboard.
// ----------------------------------------------------------------------------
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_func;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic [3:0]  flags;
    logic        ovf_sticky;
    logic        clr_sticky;
    logic        rand_start;

    int total_count;
    int bad_count;

    alu_pipe #(
        .DWIDTH (16),
        .STAGES (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .flags      (flags),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model from the arithmetic definitions: returns
    // {result[15:0], N, V, C, Z}
    function automatic logic [19:0] refModel(input logic [2:0] f,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        int ua, ub, sa, sb, r, sh;
        bit c, v;
        logic [15:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (f)
            3'd0: begin
                r = ua + ub;
                c = (r > 65535);
                v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'd1: begin
                r = ua - ub;
                c = (ua >= ub);
                v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin
                r = ua << sh;
                c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1);
            end
            3'd6: begin
                r = ua >> sh;
                c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
            end
            default: begin
                r = sa >>> sh;
                c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
            end
        endcase
        res = r[15:0];
        return {res, res[15], v, c, (res == 16'h0000)};
    endfunction

    // Presents one op for a single cycle; the pipeline is expected empty
    task automatic applyStimulus(input logic [2:0] f, input logic [15:0] a,
                                 input logic [15:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        alu_func = f;
        alu_a    = a;
        alu_b    = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // One op through an empty STAGES=2 pipe with out_ready=1: not valid one
    // cycle after entry, valid with the expected word two cycles after entry.
    // clr drives clr_sticky during the output cycle.
    task automatic runOp(input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, input string tag,
                         input logic [19:0] expected, input logic clr);
        applyStimulus(f, a, b);
        #1;
        checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        clr_sticky = clr;
        #1;
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'({alu_out, flags}), 32'(expected));
    endtask

    function automatic logic [15:0] t4OpA(input int i);
        return 16'h7000 + 16'(i * 16'h0900);
    endfunction

    function automatic logic [15:0] t4OpB(input int i);
        return 16'h1000 + 16'(i * 16'h0123);
    endfunction

    // Randomized traffic on STAGES = 1, 3, 4
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int ST = (g == 0) ? 1 : g + 2;
        logic        iv;
        logic        ir;
        logic        ov;
        logic        orr;
        logic        cs;
        logic        st;
        logic [2:0]  fn;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] ry;
        logic [3:0]  rf;
        logic        done_flag;
        logic [19:0] exp_q [$];

        alu_pipe #(
            .DWIDTH (16),
            .STAGES (ST)
        ) u_rdut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (iv),
            .in_ready   (ir),
            .alu_func   (fn),
            .alu_a      (ra),
            .alu_b      (rb),
            .out_valid  (ov),
            .out_ready  (orr),
            .alu_out    (ry),
            .flags      (rf),
            .ovf_sticky (st),
            .clr_sticky (cs)
        );

        initial begin
            int delivered;
            int cycles;
            logic sticky_m;
            logic [19:0] e;
            iv        = 1'b0;
            orr       = 1'b0;
            cs        = 1'b0;
            fn        = '0;
            ra        = '0;
            rb        = '0;
            done_flag = 1'b0;
            delivered = 0;
            cycles    = 0;
            sticky_m  = 1'b0;
            wait (rand_start === 1'b1);
            while (delivered < 1000 && cycles < 20000) begin
                @(negedge clk);
                cycles++;
                iv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
                cs  = ($urandom_range(0, 7) == 0);
                fn  = 3'($urandom);
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                if ($urandom_range(0, 7) == 0) ra = 16'h8000;
                if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
                if ($urandom_range(0, 15) == 0) rb = 16'h0000;
                #1;
                checkOutput($sformatf("s%0d_sticky", ST), 32'(st), 32'(sticky_m));
                if (ov && orr) begin
                    if (exp_q.size() == 0) begin
                        checkOutput($sformatf("s%0d_spurious_out", ST), 32'd1, 32'd0);
                        e = '0;
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput($sformatf("s%0d_op%0d", ST, delivered),
                                    32'({ry, rf}), 32'(e));
                    end
                    delivered++;
                    if (e[2]) sticky_m = 1'b1;
                    else if (cs) sticky_m = 1'b0;
                end else if (cs) begin
                    sticky_m = 1'b0;
                end
                if (iv && ir) exp_q.push_back(refModel(fn, ra, rb));
            end
            checkOutput($sformatf("s%0d_delivered", ST), 32'(delivered), 32'd1000);
            iv        = 1'b0;
            cs        = 1'b0;
            done_flag = 1'b1;
        end
    end

    initial begin
        int sent;
        int got;
        logic saw_block;
        logic all_done;

        total_count = 0;
        bad_count   = 0;
        rand_start  = 1'b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        clr_sticky  = 1'b0;
        alu_func    = '0;
        alu_a       = '0;
        alu_b       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_alu_out", 32'(alu_out), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD wrap to zero
        runOp(ALU_ADD, 16'hFFFF, 16'h0001, "add_wrap", {16'h0000, 4'b0011}, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("add_no_sticky", 32'(ovf_sticky), 32'd0);

        // SUB signed overflow, sticky set then cleared
        runOp(ALU_SUB, 16'h8000, 16'h0001, "sub_ovf", {16'h7FFF, 4'b0110}, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("sticky_set", 32'(ovf_sticky), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        #1;
        checkOutput("sticky_clr", 32'(ovf_sticky), 32'd0);

        // Set and clear in the same cycle: set wins
        runOp(ALU_SUB, 16'h8000, 16'h0001, "sub_ovf2", {16'h7FFF, 4'b0110}, 1'b1);
        @(negedge clk);
        clr_sticky = 1'b0;
        #1;
        checkOutput("sticky_set_wins", 32'(ovf_sticky), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;

        // Shifts
        runOp(ALU_SRA, 16'h8000, 16'h000F, "sra15", {16'hFFFF, 4'b1000}, 1'b0);
        runOp(ALU_SLL, 16'h8001, 16'h0001, "sll1", {16'h0002, 4'b0010}, 1'b0);
        runOp(ALU_XOR, 16'hA5A5, 16'hA5A5, "xor_zero", {16'h0000, 4'b0001}, 1'b0);

        // Back-to-back ADDs with a backpressure window on cycles 3..6
        sent      = 0;
        got       = 0;
        saw_block = 1'b0;
        for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            alu_func  = ALU_ADD;
            alu_a     = t4OpA(sent);
            alu_b     = t4OpB(sent);
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid) begin
                checkOutput($sformatf("b2b_op%0d", got), 32'({alu_out, flags}),
                            32'(refModel(ALU_ADD, t4OpA(got), t4OpB(got))));
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("b2b_count", 32'(got), 32'd8);
        checkOutput("b2b_backpressure", 32'(saw_block), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("b2b_drained", 32'(out_valid), 32'd0);

        // Reset with ops in flight
        runOp(ALU_SUB, 16'h8000, 16'h0001, "pre_rst_ovf", {16'h7FFF, 4'b0110}, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_func  = ALU_ADD;
        alu_a     = 16'h0010;
        alu_b     = 16'h0020;
        @(negedge clk);
        alu_a     = 16'h0030;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        checkOutput("inflight_valid", 32'(out_valid), 32'd1);
        checkOutput("inflight_sticky", 32'(ovf_sticky), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sticky", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("postrst_idle", 32'(out_valid), 32'd0);
        end
        runOp(ALU_ADD, 16'h1234, 16'h0001, "postrst_op", {16'h1235, 4'b0000}, 1'b0);
        @(negedge clk);

        // Randomized phase
        rand_start = 1'b1;
        all_done   = 1'b0;
        for (int c = 0; c < 50000; c++) begin
            all_done = g_rand[0].done_flag && g_rand[1].done_flag && g_rand[2].done_flag;
            if (all_done) break;
            @(posedge clk);
        end
        checkOutput("rand_all_done", 32'(all_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
